dwc_axil_cmp_bank: RTL and testbench
====================================

// Module: dwc_axil_cmp_bank
// PURPOSE
//  Parametrised AXI4-Lite duplication-with-comparison (DWC) checker bank for the multi-core
//  fault-tolerant fabric. Compares NUM_PAIRS duplicated core result buses, latches sticky
//  per-pair faults, counts mismatches, captures first-fault data and raises an interrupt.
//  Sits between the duplicated cores and the supervisor processor's AXI4-Lite interconnect.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; fixed at 32
//  C_S_AXI_ADDR_WIDTH  6   byte address width; 2**C_S_AXI_ADDR_WIDTH >= 16+8*NUM_PAIRS
//  NUM_PAIRS           2   duplicated core pairs compared, 1..6 at default address width
//  CMP_WIDTH           32  compared bus width per core, 1..32
//  ERR_CNT_WIDTH       16  saturating mismatch counter width, 1..32
// PORTS
//  ACLK           in   1                      single clock, rising edge
//  ARESETN        in   1                      asynchronous, active-low reset
//  S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave (AWADDR/ARADDR C_S_AXI_ADDR_WIDTH, WDATA/RDATA 32,
//                 WSTRB 4, AWPROT/ARPROT 3 ignored, BRESP/RRESP 2)
//  core_a_data    in   NUM_PAIRS*CMP_WIDTH    core A results, pair k at [k*CMP_WIDTH +: CMP_WIDTH]
//  core_b_data    in   NUM_PAIRS*CMP_WIDTH    core B results, same packing
//  core_valid     in   NUM_PAIRS              bit k: pair k presents data this cycle
//  core_fault     out  NUM_PAIRS              = STATUS[NUM_PAIRS-1:0]
//  mismatch_irq   out  1                      = CTRL.irq_en & |STATUS, registered
// BEHAVIOUR
//  Reset: all ready/valid outputs 0, BRESP/RRESP/RDATA 0, CTRL/STATUS/COUNT/SCRATCH/capture 0,
//   pipeline valids 0, core_fault 0, mismatch_irq 0. Reset mid-transaction drops it; no B/R issued.
//  Register map (byte offsets): 0x00 CTRL [0]enable [1]irq_en [2]clear (write-1 pulse, reads 0);
//   0x04 STATUS sticky pair faults, W1C; 0x08 COUNT RO; 0x0C SCRATCH RW;
//   0x10+8k CAP_A[k] RO, 0x14+8k CAP_B[k] RO (zero-extended to 32).
//  Write: wait for AWVALID & WVALID both high; AWREADY=WREADY=1 for exactly one cycle; next cycle
//   BVALID=1, held until BREADY. No new write accepted while BVALID pending. WSTRB honoured per byte
//   for CTRL, SCRATCH and STATUS W1C. RO or unmapped address: no effect, BRESP=SLVERR(2'b10);
//   else OKAY.
//  Read: ARVALID -> ARREADY=1 one cycle; next cycle RVALID=1 with RDATA, held stable until
//   RREADY. No new AR accepted while RVALID pending. Unmapped: RDATA=0, RRESP=SLVERR.
//   Simultaneous read and write are independent.
//  Compare pipeline: stage1 registers core_*_data/core_valid; stage2 mis[k]=v1[k]&enable&(a1!=b1).
//   core_valid at cycle N -> STATUS/COUNT/capture/core_fault/irq updated at edge ending N+2.
//  STATUS[k] sets on mis[k]; CAP_A/B[k] load only when mis[k] & STATUS[k]==0 (first fault kept).
//  COUNT += popcount(mis) each cycle, saturates at all-ones, never wraps.
//  Simultaneous events: W1C of STATUS[k] with mis[k] same cycle -> bit stays 1, capture reloads.
//   CTRL.clear with mis same cycle -> STATUS=mis, COUNT=popcount(mis), CAP reloaded for set bits.
//   enable=0 gates new mismatches only; stored state retained.
// TESTING
//  Reset, write 0x0C=0xA5A5_5A5A, read back -> RDATA 0xA5A55A5A, RRESP OKAY; other regs read 0.
//  CTRL=0x3, pair0 a=0x11 b=0x12 valid 1 cycle -> 2 cycles later STATUS=0x1, COUNT=1,
//   CAP_A0=0x11, CAP_B0=0x12, mismatch_irq=1; second mismatch a=0x7 b=0x8 -> COUNT=2, CAP unchanged.
//  Both pairs mismatch same cycle -> COUNT +2; write 0x04=0x1 with new pair0 mismatch same edge ->
//   STATUS stays 0x3; write 0x04=0x3 idle -> STATUS 0, irq 0.
//  ERR_CNT_WIDTH=4, 20 mismatch cycles -> COUNT=0xF; CTRL.clear -> COUNT=0.
//  Write 0x08 and 0x3C (NUM_PAIRS=2) -> BRESP SLVERR, no state change; hold BREADY/RREADY low 5
//   cycles -> BVALID/RVALID/RDATA stable; assert ARESETN low mid-write -> all valids 0 immediately.

Source files
------------

// File: rtl/dwc_axil_cmp_bank.sv
// dwc_axil_cmp_bank: AXI4-Lite duplication-with-comparison checker bank with sticky faults,
// saturating mismatch counter, first-fault capture and interrupt.
module dwc_axil_cmp_bank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_PAIRS          = 2,
   parameter int CMP_WIDTH          = 32,
   parameter int ERR_CNT_WIDTH      = 16
) (
   input  logic                                ACLK,
   input  logic                                ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
   input  logic [2:0]                          S_AXI_AWPROT,
   input  logic                                S_AXI_AWVALID,
   output logic                                S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
   input  logic                                S_AXI_WVALID,
   output logic                                S_AXI_WREADY,
   output logic [1:0]                          S_AXI_BRESP,
   output logic                                S_AXI_BVALID,
   input  logic                                S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
   input  logic [2:0]                          S_AXI_ARPROT,
   input  logic                                S_AXI_ARVALID,
   output logic                                S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
   output logic [1:0]                          S_AXI_RRESP,
   output logic                                S_AXI_RVALID,
   input  logic                                S_AXI_RREADY,
   input  logic [NUM_PAIRS*CMP_WIDTH-1:0]      core_a_data,
   input  logic [NUM_PAIRS*CMP_WIDTH-1:0]      core_b_data,
   input  logic [NUM_PAIRS-1:0]                core_valid,
   output logic [NUM_PAIRS-1:0]                core_fault,
   output logic                                mismatch_irq
);
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
   localparam int SW = ERR_CNT_WIDTH + 8;
   logic [NUM_PAIRS*CMP_WIDTH-1:0] a1, b1, a2, b2;
   logic [NUM_PAIRS-1:0] v1, mis, mis2, status, w1c, st_base, st_nx;
   logic [CMP_WIDTH-1:0] cap_a [NUM_PAIRS];
   logic [CMP_WIDTH-1:0] cap_b [NUM_PAIRS];
   logic [ERR_CNT_WIDTH-1:0] count, cnt_base, cnt_nx;
   logic [SW-1:0] sum;
   logic [7:0] pc;
   logic [C_S_AXI_DATA_WIDTH-1:0] scratch, bmask, wmd, rd_data;
   logic [IW-1:0] w_idx, r_idx;
   logic enable, irq_en, en_nx, ie_nx, clr, ctrl_we;
   logic aw_go, w_fire, w_ok, ar_go, r_fire, rd_ok;
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wmd};
   assign core_fault = status;
   assign w_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign r_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   for (genvar i = 0; i < C_S_AXI_DATA_WIDTH/8; i++) assign bmask[8*i +: 8] = {8{S_AXI_WSTRB[i]}};
   assign wmd    = S_AXI_WDATA & bmask;
   assign aw_go  = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_AWREADY & ~S_AXI_BVALID;
   assign w_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
   assign w_ok   = (w_idx == IW'(0)) | (w_idx == IW'(1)) | (w_idx == IW'(3));
   assign ar_go  = S_AXI_ARVALID & ~S_AXI_ARREADY & ~S_AXI_RVALID;
   assign r_fire = S_AXI_ARREADY & S_AXI_ARVALID;
   assign ctrl_we = w_fire & (w_idx == IW'(0)) & S_AXI_WSTRB[0];
   assign clr     = ctrl_we & S_AXI_WDATA[2];
   assign en_nx   = ctrl_we ? S_AXI_WDATA[0] : enable;
   assign ie_nx   = ctrl_we ? S_AXI_WDATA[1] : irq_en;
   assign w1c     = (w_fire && w_idx == IW'(1)) ? wmd[NUM_PAIRS-1:0] : '0;
   // Clear and W1C act first, so a same-edge mismatch re-sets the bit and reloads its capture.
   assign st_base  = clr ? '0 : status & ~w1c;
   assign st_nx    = st_base | mis2;
   assign cnt_base = clr ? '0 : count;
   assign sum      = SW'(cnt_base) + SW'(pc);
   assign cnt_nx   = |sum[SW-1:ERR_CNT_WIDTH] ? '1 : sum[ERR_CNT_WIDTH-1:0];
   always_comb begin
      mis = '0;
      pc  = '0;
      for (int k = 0; k < NUM_PAIRS; k++) begin
         mis[k] = v1[k] & enable & (a1[k*CMP_WIDTH +: CMP_WIDTH] != b1[k*CMP_WIDTH +: CMP_WIDTH]);
         pc     = pc + 8'(mis2[k]);
      end
   end
   always_comb begin
      rd_data = '0;
      rd_ok   = 1'b1;
      if (r_idx == IW'(0)) rd_data = {30'd0, irq_en, enable};
      else if (r_idx == IW'(1)) rd_data = 32'(status);
      else if (r_idx == IW'(2)) rd_data = 32'(count);
      else if (r_idx == IW'(3)) rd_data = scratch;
      else begin
         rd_ok = 1'b0;
         for (int k = 0; k < NUM_PAIRS; k++) begin
            if (int'(r_idx) == 4 + 2*k) begin rd_data = 32'(cap_a[k]); rd_ok = 1'b1; end
            if (int'(r_idx) == 5 + 2*k) begin rd_data = 32'(cap_b[k]); rd_ok = 1'b1; end
         end
      end
   end
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= 2'b00;
         a1 <= '0; b1 <= '0; v1 <= '0;
         a2 <= '0; b2 <= '0; mis2 <= '0;
         enable <= 1'b0; irq_en <= 1'b0;
         status <= '0; count <= '0; scratch <= '0;
         mismatch_irq <= 1'b0;
         for (int k = 0; k < NUM_PAIRS; k++) begin
            cap_a[k] <= '0;
            cap_b[k] <= '0;
         end
      end else begin
         S_AXI_AWREADY <= aw_go;
         S_AXI_WREADY  <= aw_go;
         if (w_fire) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= w_ok ? 2'b00 : 2'b10;
         end else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
         S_AXI_ARREADY <= ar_go;
         if (r_fire) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_data;
            S_AXI_RRESP  <= rd_ok ? 2'b00 : 2'b10;
         end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
         a1 <= core_a_data; b1 <= core_b_data; v1 <= core_valid;
         a2 <= a1; b2 <= b1; mis2 <= mis;
         enable <= en_nx;
         irq_en <= ie_nx;
         status <= st_nx;
         count  <= cnt_nx;
         mismatch_irq <= ie_nx & |st_nx;
         if (w_fire && w_idx == IW'(3)) scratch <= (scratch & ~bmask) | wmd;
         for (int k = 0; k < NUM_PAIRS; k++) begin
            if (mis2[k] && !st_base[k]) begin
               cap_a[k] <= a2[k*CMP_WIDTH +: CMP_WIDTH];
               cap_b[k] <= b2[k*CMP_WIDTH +: CMP_WIDTH];
            end else if (clr) begin
               cap_a[k] <= '0;
               cap_b[k] <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_dwc_axil_cmp_bank.sv
// tb_dwc_axil_cmp_bank: directed checks of the DWC checker bank with a 4-bit counter.
module tb_dwc_axil_cmp_bank;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [5:0] awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0, rdata;
   logic [3:0] wstrb = '0;
   logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
   logic awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0] bresp, rresp, core_valid = '0, core_fault;
   logic [63:0] core_a = '0, core_b = '0;
   logic [31:0] d;
   logic [1:0] r;
   int cmps = 0, errs = 0;
   always #5 clk = ~clk;
   dwc_axil_cmp_bank #(.ERR_CNT_WIDTH(4)) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .core_a_data(core_a), .core_b_data(core_b), .core_valid(core_valid),
      .core_fault(core_fault), .mismatch_irq(irq));
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic axi_wr(input logic [5:0] a, input logic [31:0] dt, input logic [3:0] s,
                         input logic br, output logic [1:0] resp);
      int n = 0;
      awaddr = a; wdata = dt; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = br;
      while (!awready && n < 20) begin cyc(1); n++; end
      chk("aw_timeout", 32'(n >= 20), 0);
      cyc(1);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin cyc(1); n++; end
      chk("b_timeout", 32'(n >= 20), 0);
      resp = bresp;
      if (br) cyc(1);
   endtask
   task automatic axi_rd(input logic [5:0] a, input logic rr, output logic [31:0] dt, output logic [1:0] resp);
      int n = 0;
      araddr = a; arvalid = 1'b1; rready = rr;
      while (!arready && n < 20) begin cyc(1); n++; end
      chk("ar_timeout", 32'(n >= 20), 0);
      cyc(1);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin cyc(1); n++; end
      chk("r_timeout", 32'(n >= 20), 0);
      dt = rdata; resp = rresp;
      if (rr) cyc(1);
   endtask
   task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp, input logic [1:0] er);
      logic [31:0] dt;
      logic [1:0] rs;
      axi_rd(a, 1'b1, dt, rs);
      chk(tag, dt, exp);
      chk({tag, "_resp"}, 32'(rs), 32'(er));
   endtask
   task automatic pulse(input logic [31:0] a0, b0, a1, b1, input logic [1:0] v);
      core_a = {a1, a0}; core_b = {b1, b0}; core_valid = v;
      cyc(1);
      core_valid = '0;
      cyc(2);
   endtask
   initial begin
      cyc(3);
      chk("rst_awready", 32'(awready), 0);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_arready", 32'(arready), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_fault", 32'(core_fault), 0);
      chk("rst_irq", 32'(irq), 0);
      rst_n = 1'b1;
      cyc(2);
      axi_wr(6'h0C, 32'hA5A5_5A5A, 4'hF, 1'b1, r);
      chk("scr_bresp", 32'(r), 0);
      rd_chk("scr_rd", 6'h0C, 32'hA5A5_5A5A, 2'b00);
      rd_chk("ctrl0", 6'h00, 0, 2'b00);
      rd_chk("stat0", 6'h04, 0, 2'b00);
      rd_chk("cnt0", 6'h08, 0, 2'b00);
      rd_chk("capa0_0", 6'h10, 0, 2'b00);
      axi_wr(6'h00, 32'h3, 4'hF, 1'b1, r);
      core_a = {32'h0, 32'h11}; core_b = {32'h0, 32'h12}; core_valid = 2'b01;
      cyc(1);
      core_valid = '0;
      cyc(1);
      chk("fault_early", 32'(core_fault), 0);
      cyc(1);
      chk("fault_n2", 32'(core_fault), 1);
      chk("irq_set", 32'(irq), 1);
      rd_chk("stat1", 6'h04, 1, 2'b00);
      rd_chk("cnt1", 6'h08, 1, 2'b00);
      rd_chk("capa0", 6'h10, 32'h11, 2'b00);
      rd_chk("capb0", 6'h14, 32'h12, 2'b00);
      pulse(32'h7, 32'h8, 0, 0, 2'b01);
      rd_chk("cnt2", 6'h08, 2, 2'b00);
      rd_chk("capa0_kept", 6'h10, 32'h11, 2'b00);
      pulse(32'h1, 32'h3, 32'h2, 32'h4, 2'b11);
      rd_chk("cnt4", 6'h08, 4, 2'b00);
      rd_chk("stat3", 6'h04, 3, 2'b00);
      rd_chk("capa1", 6'h18, 32'h2, 2'b00);
      rd_chk("capb1", 6'h1C, 32'h4, 2'b00);
      // W1C of pair0 committed on the same edge as a fresh pair0 mismatch
      core_a = {32'h0, 32'h21}; core_b = {32'h0, 32'h22}; core_valid = 2'b01;
      cyc(1);
      core_valid = '0;
      awaddr = 6'h04; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      cyc(1);
      chk("w1c_align", 32'(awready), 1);
      cyc(1);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("w1c_bvalid", 32'(bvalid), 1);
      cyc(1);
      rd_chk("stat_w1c_race", 6'h04, 3, 2'b00);
      rd_chk("cnt5", 6'h08, 5, 2'b00);
      rd_chk("capa0_reload", 6'h10, 32'h21, 2'b00);
      axi_wr(6'h04, 32'h3, 4'hF, 1'b1, r);
      rd_chk("stat_clr", 6'h04, 0, 2'b00);
      chk("irq_clr", 32'(irq), 0);
      axi_wr(6'h00, 32'h2, 4'hF, 1'b1, r);
      pulse(32'h5, 32'h6, 0, 0, 2'b01);
      rd_chk("stat_dis", 6'h04, 0, 2'b00);
      rd_chk("cnt_dis", 6'h08, 5, 2'b00);
      axi_wr(6'h00, 32'h3, 4'hF, 1'b1, r);
      core_a = {32'h0, 32'h1}; core_b = {32'h0, 32'h0}; core_valid = 2'b01;
      cyc(20);
      core_valid = '0;
      cyc(3);
      rd_chk("cnt_sat", 6'h08, 32'hF, 2'b00);
      axi_wr(6'h00, 32'h7, 4'hF, 1'b1, r);
      rd_chk("cnt_clear", 6'h08, 0, 2'b00);
      rd_chk("stat_clear", 6'h04, 0, 2'b00);
      rd_chk("ctrl_rd", 6'h00, 3, 2'b00);
      axi_wr(6'h08, 32'h1234, 4'hF, 1'b1, r);
      chk("ro_bresp", 32'(r), 2);
      rd_chk("cnt_ro", 6'h08, 0, 2'b00);
      axi_wr(6'h3C, 32'h1, 4'hF, 1'b1, r);
      chk("unmap_bresp", 32'(r), 2);
      rd_chk("unmap_rd", 6'h3C, 0, 2'b10);
      axi_wr(6'h0C, 32'hFFFF_FFFF, 4'h1, 1'b1, r);
      axi_wr(6'h0C, 32'h0, 4'h8, 1'b1, r);
      rd_chk("scr_strb", 6'h0C, 32'h00A5_5AFF, 2'b00);
      axi_wr(6'h0C, 32'h1234_5678, 4'hF, 1'b0, r);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("b_hold", {30'd0, bresp}, 0);
         chk("b_hold_v", 32'(bvalid), 1);
      end
      bready = 1'b1;
      cyc(1);
      chk("b_drop", 32'(bvalid), 0);
      axi_rd(6'h0C, 1'b0, d, r);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("r_hold_v", 32'(rvalid), 1);
         chk("r_hold_d", rdata, 32'h1234_5678);
      end
      rready = 1'b1;
      cyc(1);
      chk("r_drop", 32'(rvalid), 0);
      awaddr = 6'h0C; wdata = 32'hDEAD; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      cyc(1);
      chk("mid_awready", 32'(awready), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_awready", 32'(awready), 0);
      chk("mid_rst_wready", 32'(wready), 0);
      chk("mid_rst_bvalid", 32'(bvalid), 0);
      awvalid = 1'b0; wvalid = 1'b0;
      cyc(2);
      chk("mid_rst_bvalid2", 32'(bvalid), 0);
      rst_n = 1'b1;
      cyc(1);
      rd_chk("scr_after_rst", 6'h0C, 0, 2'b00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule
